arbiter_core: RTL and testbench



---
 rtl/arbiter_core_if.sv | 29 ++
 rtl/arbiter_core.sv | 100 ++++++++++
 tb/tb_arbiter_core.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_core_if.sv
// Request/grant bundle between a set of requesters and arbiter_core.
// The arbiter sits on the slave side; requesters drive the master side.
interface arbiter_core_if #(
  parameter int PORTS = 4
);
  localparam int EW = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS-1:0] request;
  logic [PORTS-1:0] acknowledge;
  logic [PORTS-1:0] grant;
  logic             grant_valid;
  logic [EW-1:0]    grant_encoded;

  modport master (
    output request,
    output acknowledge,
    input  grant,
    input  grant_valid,
    input  grant_encoded
  );

  modport slave (
    input  request,
    input  acknowledge,
    output grant,
    output grant_valid,
    output grant_encoded
  );
endinterface

// File: rtl/arbiter_core.sv
// N-way request arbiter with registered one-hot grant, fixed or round-robin
// selection, and optional grant blocking released by request drop or acknowledge.
module arbiter_core #(
  parameter int PORTS                 = 4,
  parameter int ARB_TYPE_ROUND_ROBIN  = 0,
  parameter int ARB_BLOCK             = 0,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 0
) (
  input logic           clk,
  input logic           rst,
  arbiter_core_if.slave bus
);
  localparam int EW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [PORTS-1:0] ONES = '1;
  localparam logic [PORTS-1:0] ONE  = PORTS'(1);

  logic [PORTS-1:0] grant_q, grant_d;
  logic [PORTS-1:0] mask_q, mask_d;
  logic [PORTS-1:0] masked;
  logic             valid_q, valid_d;
  logic [EW-1:0]    enc_q, enc_d;
  logic             hold;
  int               k;

  function automatic int pick(input logic [PORTS-1:0] v);
    int r;
    r = 0;
    if (ARB_LSB_HIGH_PRIORITY != 0) begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (v[i]) r = i;
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (v[i]) r = i;
      end
    end
    return r;
  endfunction

  always_comb begin
    grant_d = grant_q;
    valid_d = valid_q;
    enc_d   = enc_q;
    mask_d  = mask_q;
    masked  = bus.request & mask_q;
    hold    = 1'b0;
    k       = 0;

    // Ack-released blocking keeps the grant even after the request drops.
    if (ARB_BLOCK != 0 && ARB_BLOCK_ACK == 0) begin
      hold = |(grant_q & bus.request);
    end else if (ARB_BLOCK != 0) begin
      hold = valid_q && ((grant_q & bus.acknowledge) == '0);
    end

    if (!hold) begin
      if (|bus.request) begin
        if (ARB_TYPE_ROUND_ROBIN != 0 && |masked) begin
          k = pick(masked);
        end else begin
          k = pick(bus.request);
        end
        grant_d = ONE << k;
        valid_d = 1'b1;
        enc_d   = EW'(k);
        if (ARB_LSB_HIGH_PRIORITY != 0) begin
          mask_d = ONES << (k + 1);
        end else begin
          mask_d = ONES >> (PORTS - k);
        end
      end else begin
        grant_d = '0;
        valid_d = 1'b0;
        enc_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      enc_q   <= '0;
      mask_q  <= '0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      enc_q   <= enc_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = valid_q;
  assign bus.grant_encoded = enc_q;

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_valid:  assert property (@(posedge clk) disable iff (rst) valid_q == (|grant_q));
endmodule

// File: tb/tb_arbiter_core.sv
// Bench for arbiter_core: six configurations driven side by side and compared
// every cycle against a rotating-pointer reference model.
module tb_arbiter_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam int ND = 6;

  typedef struct {
    int ports;
    bit rr;
    bit blk;
    bit ack_rel;
    bit lsb;
  } cfg_t;

  typedef struct {
    int g;     // granted index, -1 when idle
    int last;  // last index granted since reset, -1 when none
  } st_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] g;
    logic       v;
    logic [1:0] e;
  } vec_t;

  cfg_t       cfg [ND];
  st_t        st  [ND];
  logic [3:0] req [ND];
  logic [3:0] ack [ND];
  string      nm  [ND];
  int total = 0;
  int bad   = 0;

  arbiter_core_if #(.PORTS(4)) i_fp ();
  arbiter_core_if #(.PORTS(4)) i_rrl ();
  arbiter_core_if #(.PORTS(4)) i_rrm ();
  arbiter_core_if #(.PORTS(4)) i_ba ();
  arbiter_core_if #(.PORTS(4)) i_br ();
  arbiter_core_if #(.PORTS(1)) i_p1 ();

  arbiter_core #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
                 .ARB_LSB_HIGH_PRIORITY(1)) u_fp (.clk(clk), .rst(rst), .bus(i_fp));
  arbiter_core #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
                 .ARB_LSB_HIGH_PRIORITY(1)) u_rrl (.clk(clk), .rst(rst), .bus(i_rrl));
  arbiter_core #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
                 .ARB_LSB_HIGH_PRIORITY(0)) u_rrm (.clk(clk), .rst(rst), .bus(i_rrm));
  arbiter_core #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
                 .ARB_LSB_HIGH_PRIORITY(1)) u_ba (.clk(clk), .rst(rst), .bus(i_ba));
  arbiter_core #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
                 .ARB_LSB_HIGH_PRIORITY(1)) u_br (.clk(clk), .rst(rst), .bus(i_br));
  arbiter_core #(.PORTS(1), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
                 .ARB_LSB_HIGH_PRIORITY(0)) u_p1 (.clk(clk), .rst(rst), .bus(i_p1));

  // Reference: round-robin resumes the search just past the last winner,
  // walking toward lower priority and wrapping.
  function automatic st_t step(input cfg_t c, input st_t s,
                               input logic [3:0] r, input logic [3:0] a);
    st_t n;
    int  start, idx;
    n = s;
    if (c.blk && !c.ack_rel && s.g >= 0 && r[s.g]) return n;
    if (c.blk && c.ack_rel && s.g >= 0 && !a[s.g]) return n;
    n.g = -1;
    if (c.rr && s.last >= 0) start = c.lsb ? s.last + 1 : s.last - 1;
    else                     start = c.lsb ? 0 : c.ports - 1;
    for (int i = 0; i < c.ports; i++) begin
      idx = c.lsb ? start + i : start - i;
      idx = ((idx % c.ports) + c.ports) % c.ports;
      if (r[idx]) begin
        n.g    = idx;
        n.last = idx;
        break;
      end
    end
    return n;
  endfunction

  task automatic drive();
    i_fp.request  = req[0]; i_fp.acknowledge  = ack[0];
    i_rrl.request = req[1]; i_rrl.acknowledge = ack[1];
    i_rrm.request = req[2]; i_rrm.acknowledge = ack[2];
    i_ba.request  = req[3]; i_ba.acknowledge  = ack[3];
    i_br.request  = req[4]; i_br.acknowledge  = ack[4];
    i_p1.request  = req[5][0:0]; i_p1.acknowledge = ack[5][0:0];
  endtask

  task automatic observe(input int n, output logic [3:0] g, output logic v, output logic [1:0] e);
    g = '0; v = 1'b0; e = '0;
    case (n)
      0: begin g = i_fp.grant;  v = i_fp.grant_valid;  e = i_fp.grant_encoded;  end
      1: begin g = i_rrl.grant; v = i_rrl.grant_valid; e = i_rrl.grant_encoded; end
      2: begin g = i_rrm.grant; v = i_rrm.grant_valid; e = i_rrm.grant_encoded; end
      3: begin g = i_ba.grant;  v = i_ba.grant_valid;  e = i_ba.grant_encoded;  end
      4: begin g = i_br.grant;  v = i_br.grant_valid;  e = i_br.grant_encoded;  end
      default: begin g = {3'b000, i_p1.grant}; v = i_p1.grant_valid; e = {1'b0, i_p1.grant_encoded}; end
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int packed_out(input logic [3:0] g, input logic v, input logic [1:0] e);
    return int'({g, v, e});
  endfunction

  function automatic int model_out(input st_t s);
    logic [3:0] g;
    g = '0;
    if (s.g >= 0) g[s.g] = 1'b1;
    return int'({g, s.g >= 0, (s.g >= 0) ? 2'(s.g) : 2'd0});
  endfunction

  task automatic reset_models();
    for (int n = 0; n < ND; n++) begin
      st[n].g = -1;
      st[n].last = -1;
    end
  endtask

  task automatic tick();
    logic [3:0] g; logic v; logic [1:0] e;
    drive();
    for (int n = 0; n < ND; n++) st[n] = step(cfg[n], st[n], req[n], ack[n]);
    @(posedge clk);
    #1;
    for (int n = 0; n < ND; n++) begin
      observe(n, g, v, e);
      chk({"model_", nm[n]}, packed_out(g, v, e), model_out(st[n]));
    end
  endtask

  task automatic chk_grant(input string name, input int n, input logic [3:0] exp_g);
    logic [3:0] g; logic v; logic [1:0] e;
    observe(n, g, v, e);
    chk(name, int'(g), int'(exp_g));
  endtask

  vec_t vt [8];

  initial begin
    logic [3:0] g; logic v; logic [1:0] e;
    logic [3:0] rr_seq [7];

    cfg[0] = '{4, 1'b0, 1'b0, 1'b1, 1'b1}; nm[0] = "fp";
    cfg[1] = '{4, 1'b1, 1'b0, 1'b1, 1'b1}; nm[1] = "rrl";
    cfg[2] = '{4, 1'b1, 1'b0, 1'b1, 1'b0}; nm[2] = "rrm";
    cfg[3] = '{4, 1'b1, 1'b1, 1'b1, 1'b1}; nm[3] = "ba";
    cfg[4] = '{4, 1'b1, 1'b1, 1'b0, 1'b1}; nm[4] = "br";
    cfg[5] = '{1, 1'b0, 1'b1, 1'b1, 1'b0}; nm[5] = "p1";
    for (int n = 0; n < ND; n++) begin req[n] = '0; ack[n] = '0; end
    reset_models();

    vt[0] = '{4'b1010, 4'b0010, 1'b1, 2'd1};
    vt[1] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
    vt[2] = '{4'b1000, 4'b1000, 1'b1, 2'd3};
    vt[3] = '{4'b1100, 4'b0100, 1'b1, 2'd2};
    vt[4] = '{4'b0111, 4'b0001, 1'b1, 2'd0};
    vt[5] = '{4'b1111, 4'b0001, 1'b1, 2'd0};
    vt[6] = '{4'b0110, 4'b0010, 1'b1, 2'd1};
    vt[7] = '{4'b0000, 4'b0000, 1'b0, 2'd0};

    drive();
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < ND; n++) begin
      observe(n, g, v, e);
      chk({"reset_", nm[n]}, packed_out(g, v, e), 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      req[0] = vt[i].req;
      tick();
      observe(0, g, v, e);
      chk($sformatf("fp_vec%0d", i), packed_out(g, v, e), packed_out(vt[i].g, vt[i].v, vt[i].e));
    end

    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    req[1] = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_grant($sformatf("rrl_%0d", i), 1, rr_seq[i]);
    end
    req[1] = '0;

    req[2] = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_grant($sformatf("rrm_%0d", i), 2, (i % 2 == 0) ? 4'b0100 : 4'b0001);
    end
    req[2] = '0;

    req[3] = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_grant($sformatf("ba_hold%0d", i), 3, 4'b0001);
    end
    ack[3] = 4'b0010; tick(); chk_grant("ba_wrong_ack", 3, 4'b0001);
    ack[3] = 4'b0001; tick(); chk_grant("ba_ack", 3, 4'b0010);
    ack[3] = 4'b0010; req[3] = 4'b0001; tick(); chk_grant("ba_regrant", 3, 4'b0001);
    ack[3] = 4'b0000; req[3] = 4'b0000;
    tick(); chk_grant("ba_reqdrop0", 3, 4'b0001);
    tick(); chk_grant("ba_reqdrop1", 3, 4'b0001);

    req[4] = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_grant($sformatf("br_hold%0d", i), 4, 4'b0010);
    end
    req[4] = 4'b0100; tick(); chk_grant("br_release", 4, 4'b0100);

    #2 rst = 1'b1;
    #1;
    chk_grant("async_rst_br", 4, 4'b0000);
    chk_grant("async_rst_ba", 3, 4'b0000);
    observe(4, g, v, e);
    chk("async_rst_br_valid", int'(v), 0);
    reset_models();
    #1 rst = 1'b0;
    req[4] = 4'b1100; req[1] = 4'b1100; ack[3] = '0; req[3] = '0;
    tick();
    chk_grant("post_rst_br", 4, 4'b0100);
    chk_grant("post_rst_rrl", 1, 4'b0100);

    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < ND; n++) begin
        req[n] = 4'($urandom_range(0, 15));
        ack[n] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        if (cfg[n].ports == 1) begin
          req[n] = req[n] & 4'b0001;
          ack[n] = ack[n] & 4'b0001;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
